trap_sequencer: RTL and testbench
=================================

# trap_sequencer

Control block between the pipeline and the CSR file. It collects synchronous exceptions, masked interrupt requests and `mret` requests. Exceptions take priority over interrupts. For a trap it drives the CSR file's trap entry port for one cycle and waits for the CSR file's handled/target response. It stalls the pipeline for the whole sequence and then issues a single PC redirect to the trap vector or to `mepc`.

## Interface

- DATA_WIDTH, 32, width of PC, trap value and CSR data
- ACK_TIMEOUT, 15, maximum cycles spent waiting for `trap_handled` before a fault is raised (1..255)

- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- exc_valid  in  1  pipeline reports a synchronous exception this cycle
- exc_cause  in  4  exception code
- exc_value  in  DATA_WIDTH  faulting address or instruction (mtval)
- exc_pc  in  DATA_WIDTH  PC of the faulting instruction
- cur_pc  in  DATA_WIDTH  PC of the next instruction to retire, used as mepc for interrupts
- irq_ext, irq_soft, irq_timer  in  1 each  level interrupt requests
- mstatus_mie  in  1  global interrupt enable, from the CSR file
- mie_bits  in  3  per-source enables: {ext, soft, timer}
- mret_valid  in  1  pipeline decoded `mret`
- mepc  in  DATA_WIDTH  current mepc value, from the CSR file
- trap  out  1  one-cycle trap entry pulse to the CSR file
- trap_cause  out  4  cause code to the CSR file
- trap_is_irq  out  1  the cause is an interrupt (interrupt bit of mcause)
- trap_value  out  DATA_WIDTH  mtval to the CSR file
- trap_pc  out  DATA_WIDTH  mepc to the CSR file
- trap_handled  in  1  CSR file acknowledge
- trap_target_pc  in  DATA_WIDTH  vector address, valid together with `trap_handled`
- mret_pulse  out  1  one-cycle pulse telling the CSR file to restore mstatus
- pipe_stall  out  1  holds the pipeline
- redirect_valid  out  1  one-cycle PC redirect
- redirect_pc  out  DATA_WIDTH  redirect target, word aligned
- seq_fault  out  1  sticky flag: acknowledge timeout occurred

## Operation

- States: IDLE, ISSUE, WAIT_ACK, REDIRECT.
- `pipe_stall` is high whenever state is not IDLE. It is decoded from the state register, with no combinational path from the inputs.
- **IDLE**: inputs are evaluated in this priority order.
  1. `exc_valid` goes first. The block latches cause, value and pc, sets is_irq to 0 and goes to ISSUE.
  2. Otherwise an interrupt is taken if `mstatus_mie` is high and the source is pending and enabled. Priority among sources is ext (code 11), then soft (3), then timer (7). The block latches the code, value = 0, pc = `cur_pc`, is_irq = 1 and goes to ISSUE.
  3. Otherwise, if `mret_valid` is high, the block pulses `mret_pulse`, sets redirect_pc = `mepc` & ~3 and goes to REDIRECT.
  4. Otherwise it stays in IDLE.
- **ISSUE**: `trap` is 1 for exactly this cycle and `trap_*` carry the latched values. The timeout counter is cleared. Next state is WAIT_ACK.
- **WAIT_ACK**:
  - When `trap_handled` is 1, the block latches redirect_pc = `trap_target_pc` & ~3 and goes to REDIRECT.
  - On every cycle without the acknowledge the counter increments. When the counter equals ACK_TIMEOUT, the block sets `seq_fault`, sets redirect_pc = 0 and goes to REDIRECT.
- **REDIRECT**: `redirect_valid` is 1 for this cycle, then the state returns to IDLE.
- Inputs are ignored while not in IDLE. `exc_valid`, `mret_valid` and interrupts arriving then are not queued. Level interrupts are re-evaluated on return to IDLE.
- `trap_cause`, `trap_value`, `trap_pc` and `trap_is_irq` hold their last latched values between traps.
- `seq_fault` is cleared only by reset.

## Timing

- Reset value of every output and register is 0: `trap`, `trap_cause`, `trap_is_irq`, `trap_value`, `trap_pc`, `mret_pulse`, `pipe_stall`, `redirect_valid`, `redirect_pc`, `seq_fault`. The state resets to IDLE.
- Exception or interrupt sampled in cycle N:
  - `trap` high in N+1.
  - The CSR file answers with a registered `trap_handled` in N+2, so WAIT_ACK normally lasts 1 cycle.
  - `redirect_valid` high in N+3.
  - `pipe_stall` high from N+1 to N+3 and low in N+4.
- mret sampled in cycle N: `mret_pulse` high in N+1 together with REDIRECT, so `redirect_valid` is also high in N+1. `pipe_stall` is high in N+1 only.
- An exception and `mret_valid` in the same cycle: the exception wins and no `mret_pulse` is issued.
- An exception and an enabled interrupt in the same cycle: the exception wins. The interrupt is taken on the first IDLE cycle afterwards if it is still pending.
- `trap_handled` seen while not in WAIT_ACK is ignored.
- Reset asserted mid-sequence: all outputs go to 0 asynchronously and no pending trap is replayed.

## Test plan

- **Exception:** in IDLE, drive `exc_valid` = 1, cause = 2, value = 0xDEADBEEF, pc = 0x100. The model CSR file acks in the next cycle with target 0x203.
  - Expect `trap` pulse with cause 2, is_irq 0, value 0xDEADBEEF, pc 0x100.
  - Expect `redirect_valid` with pc 0x200, 3 cycles after the input.
  - Expect `pipe_stall` high for exactly 3 cycles.
- **Interrupt priority:** `mstatus_mie` = 1, `mie_bits` = 3'b111, all three irqs high, `cur_pc` = 0x40.
  - Expect cause 11, is_irq 1, trap_pc 0x40.
  - Repeat with `irq_ext` = 0: expect cause 3.
- **Masking:** irq_timer = 1 with `mstatus_mie` = 0, then with `mie_bits` = 3'b110.
  - Expect no `trap` and `pipe_stall` staying 0 for 20 cycles in both cases.
- **mret:** `mret_valid` = 1, `mepc` = 0x1236.
  - Expect `mret_pulse` and `redirect_valid` in the same cycle, redirect_pc 0x1234, one stall cycle.
  - Then assert `exc_valid` together with `mret_valid`: expect the trap path and no `mret_pulse`.
- **Timeout:** ACK_TIMEOUT = 15, hold `trap_handled` = 0.
  - Expect `seq_fault` = 1 and `redirect_valid` with pc 0 at the 16th cycle after `trap`.
  - `seq_fault` stays high through a subsequent good trap.
- **Reset mid-sequence:** assert `rst_n` = 0 during WAIT_ACK.
  - Expect all outputs 0 immediately.
  - After release, no `trap` or `redirect_valid` unless new input arrives.

Source files
------------

// File: rtl/trap_sequencer.sv
// trap_sequencer: sequences exception, interrupt and mret handoff
// between the pipeline and the CSR file, then redirects the PC.
module trap_sequencer #(
  parameter int DATA_WIDTH  = 32,
  parameter int ACK_TIMEOUT = 15
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  exc_valid,
  input  logic [3:0]            exc_cause,
  input  logic [DATA_WIDTH-1:0] exc_value,
  input  logic [DATA_WIDTH-1:0] exc_pc,
  input  logic [DATA_WIDTH-1:0] cur_pc,
  input  logic                  irq_ext,
  input  logic                  irq_soft,
  input  logic                  irq_timer,
  input  logic                  mstatus_mie,
  input  logic [2:0]            mie_bits,
  input  logic                  mret_valid,
  input  logic [DATA_WIDTH-1:0] mepc,
  output logic                  trap,
  output logic [3:0]            trap_cause,
  output logic                  trap_is_irq,
  output logic [DATA_WIDTH-1:0] trap_value,
  output logic [DATA_WIDTH-1:0] trap_pc,
  input  logic                  trap_handled,
  input  logic [DATA_WIDTH-1:0] trap_target_pc,
  output logic                  mret_pulse,
  output logic                  pipe_stall,
  output logic                  redirect_valid,
  output logic [DATA_WIDTH-1:0] redirect_pc,
  output logic                  seq_fault
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    REDIRECT = 2'd3
  } state_t;

  state_t state, state_d;

  logic [7:0]            cnt, cnt_d;
  logic [8:0]            cnt_inc;
  logic [3:0]            cause_d;
  logic                  is_irq_d;
  logic [DATA_WIDTH-1:0] value_d;
  logic [DATA_WIDTH-1:0] pc_d;
  logic                  mret_d;
  logic                  fault_d;
  logic [DATA_WIDTH-1:0] rpc_d;

  logic [2:0] pend;
  logic [2:0] sel;
  logic [3:0] irq_code;
  logic       irq_any;

  assign pend    = {irq_ext, irq_soft, irq_timer}
                 & mie_bits & {3{mstatus_mie}};
  assign sel[2]  = pend[2];
  assign sel[1]  = pend[1] & ~pend[2];
  assign sel[0]  = pend[0] & ~(|pend[2:1]);
  assign irq_any = |pend;
  assign cnt_inc = {1'b0, cnt} + 9'd1;

  assign trap           = (state == ISSUE);
  assign redirect_valid = (state == REDIRECT);
  assign pipe_stall     = (state != IDLE);

  // Encode the winning interrupt source: ext > soft > timer
  always_comb begin
    irq_code = 4'd0;
    unique case (1'b1)
      sel[2]:  irq_code = 4'd11;
      sel[1]:  irq_code = 4'd3;
      sel[0]:  irq_code = 4'd7;
      default: irq_code = 4'd0;
    endcase
  end

  // Next-state and next-value logic for the trap sequence
  always_comb begin
    state_d  = state;
    cnt_d    = cnt;
    cause_d  = trap_cause;
    is_irq_d = trap_is_irq;
    value_d  = trap_value;
    pc_d     = trap_pc;
    mret_d   = 1'b0;
    fault_d  = seq_fault;
    rpc_d    = redirect_pc;
    unique case (state)
      IDLE: begin
        if (exc_valid) begin
          cause_d  = exc_cause;
          is_irq_d = 1'b0;
          value_d  = exc_value;
          pc_d     = exc_pc;
          state_d  = ISSUE;
        end else if (irq_any) begin
          cause_d  = irq_code;
          is_irq_d = 1'b1;
          value_d  = '0;
          pc_d     = cur_pc;
          state_d  = ISSUE;
        end else if (mret_valid) begin
          mret_d  = 1'b1;
          rpc_d   = {mepc[DATA_WIDTH-1:2], 2'b00};
          state_d = REDIRECT;
        end
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (trap_handled) begin
          rpc_d   = {trap_target_pc[DATA_WIDTH-1:2], 2'b00};
          state_d = REDIRECT;
        end else if (cnt_inc == 9'(ACK_TIMEOUT)) begin
          fault_d = 1'b1;
          rpc_d   = '0;
          state_d = REDIRECT;
        end else begin
          cnt_d = cnt_inc[7:0];
        end
      end
      REDIRECT: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, latched trap fields and sticky fault flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      trap_cause  <= '0;
      trap_is_irq <= 1'b0;
      trap_value  <= '0;
      trap_pc     <= '0;
      mret_pulse  <= 1'b0;
      seq_fault   <= 1'b0;
      redirect_pc <= '0;
    end else begin
      state       <= state_d;
      cnt         <= cnt_d;
      trap_cause  <= cause_d;
      trap_is_irq <= is_irq_d;
      trap_value  <= value_d;
      trap_pc     <= pc_d;
      mret_pulse  <= mret_d;
      seq_fault   <= fault_d;
      redirect_pc <= rpc_d;
    end
  end

endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed vectors for trap_sequencer
// with hand-computed expected values.
module tb_trap_sequencer;

  logic        clk;
  logic        rst_n;
  logic        exc_valid;
  logic [3:0]  exc_cause;
  logic [31:0] exc_value;
  logic [31:0] exc_pc;
  logic [31:0] cur_pc;
  logic        irq_ext;
  logic        irq_soft;
  logic        irq_timer;
  logic        mstatus_mie;
  logic [2:0]  mie_bits;
  logic        mret_valid;
  logic [31:0] mepc;
  logic        trap;
  logic [3:0]  trap_cause;
  logic        trap_is_irq;
  logic [31:0] trap_value;
  logic [31:0] trap_pc;
  logic        trap_handled;
  logic [31:0] trap_target_pc;
  logic        mret_pulse;
  logic        pipe_stall;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        seq_fault;

  int checks;
  int failures;
  int seen;

  trap_sequencer #(
    .DATA_WIDTH (32),
    .ACK_TIMEOUT(15)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .exc_valid     (exc_valid),
    .exc_cause     (exc_cause),
    .exc_value     (exc_value),
    .exc_pc        (exc_pc),
    .cur_pc        (cur_pc),
    .irq_ext       (irq_ext),
    .irq_soft      (irq_soft),
    .irq_timer     (irq_timer),
    .mstatus_mie   (mstatus_mie),
    .mie_bits      (mie_bits),
    .mret_valid    (mret_valid),
    .mepc          (mepc),
    .trap          (trap),
    .trap_cause    (trap_cause),
    .trap_is_irq   (trap_is_irq),
    .trap_value    (trap_value),
    .trap_pc       (trap_pc),
    .trap_handled  (trap_handled),
    .trap_target_pc(trap_target_pc),
    .mret_pulse    (mret_pulse),
    .pipe_stall    (pipe_stall),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .seq_fault     (seq_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Called in the ISSUE cycle; CSR model acks during WAIT_ACK
  task automatic finish_ack(input string tag,
                            input logic [31:0] tgt,
                            input logic [31:0] exp_rpc);
    tick();
    trap_handled   = 1'b1;
    trap_target_pc = tgt;
    tick();
    trap_handled = 1'b0;
    check({tag, "_rv"}, 32'(redirect_valid), 32'd1);
    check({tag, "_rpc"}, redirect_pc, exp_rpc);
    tick();
    check({tag, "_idle"}, 32'(pipe_stall), 32'd0);
  endtask

  initial begin
    checks         = 0;
    failures       = 0;
    rst_n          = 1'b0;
    exc_valid      = 1'b0;
    exc_cause      = 4'd0;
    exc_value      = '0;
    exc_pc         = '0;
    cur_pc         = '0;
    irq_ext        = 1'b0;
    irq_soft       = 1'b0;
    irq_timer      = 1'b0;
    mstatus_mie    = 1'b0;
    mie_bits       = 3'b000;
    mret_valid     = 1'b0;
    mepc           = '0;
    trap_handled   = 1'b0;
    trap_target_pc = '0;

    // reset state
    tick();
    tick();
    check("rst_trap", 32'(trap), 32'd0);
    check("rst_stall", 32'(pipe_stall), 32'd0);
    check("rst_rv", 32'(redirect_valid), 32'd0);
    check("rst_rpc", redirect_pc, 32'd0);
    check("rst_fault", 32'(seq_fault), 32'd0);
    check("rst_cause", 32'(trap_cause), 32'd0);
    check("rst_mret", 32'(mret_pulse), 32'd0);
    rst_n = 1'b1;
    tick();

    // exception
    exc_valid = 1'b1;
    exc_cause = 4'd2;
    exc_value = 32'hDEADBEEF;
    exc_pc    = 32'h100;
    seen      = 0;
    tick();
    exc_valid = 1'b0;
    seen += int'(pipe_stall);
    check("exc_trap", 32'(trap), 32'd1);
    check("exc_cause", 32'(trap_cause), 32'd2);
    check("exc_irq", 32'(trap_is_irq), 32'd0);
    check("exc_val", trap_value, 32'hDEADBEEF);
    check("exc_pc", trap_pc, 32'h100);
    tick();
    seen += int'(pipe_stall);
    check("exc_trap_once", 32'(trap), 32'd0);
    check("exc_rv_early", 32'(redirect_valid), 32'd0);
    trap_handled   = 1'b1;
    trap_target_pc = 32'h203;
    tick();
    trap_handled = 1'b0;
    seen += int'(pipe_stall);
    check("exc_rv", 32'(redirect_valid), 32'd1);
    check("exc_rpc", redirect_pc, 32'h200);
    check("exc_nomret", 32'(mret_pulse), 32'd0);
    tick();
    seen += int'(pipe_stall);
    check("exc_rv_once", 32'(redirect_valid), 32'd0);
    tick();
    seen += int'(pipe_stall);
    check("exc_stall_cnt", 32'(seen), 32'd3);
    check("exc_hold", 32'(trap_cause), 32'd2);

    // interrupt priority
    mstatus_mie = 1'b1;
    mie_bits    = 3'b111;
    cur_pc      = 32'h40;
    irq_ext     = 1'b1;
    irq_soft    = 1'b1;
    irq_timer   = 1'b1;
    tick();
    irq_ext   = 1'b0;
    irq_soft  = 1'b0;
    irq_timer = 1'b0;
    check("irq_trap", 32'(trap), 32'd1);
    check("irq_cause", 32'(trap_cause), 32'd11);
    check("irq_isirq", 32'(trap_is_irq), 32'd1);
    check("irq_pc", trap_pc, 32'h40);
    check("irq_val", trap_value, 32'd0);
    finish_ack("irq1", 32'h81, 32'h80);
    irq_soft  = 1'b1;
    irq_timer = 1'b1;
    tick();
    irq_soft  = 1'b0;
    irq_timer = 1'b0;
    check("irq_soft", 32'(trap_cause), 32'd3);
    finish_ack("irq2", 32'h90, 32'h90);
    irq_timer = 1'b1;
    tick();
    irq_timer = 1'b0;
    check("irq_timer", 32'(trap_cause), 32'd7);
    finish_ack("irq3", 32'hA2, 32'hA0);

    // masking
    irq_timer   = 1'b1;
    mstatus_mie = 1'b0;
    mie_bits    = 3'b111;
    seen        = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen += int'(trap) + int'(pipe_stall);
    end
    check("mask_mie", 32'(seen), 32'd0);
    mstatus_mie = 1'b1;
    mie_bits    = 3'b110;
    seen        = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen += int'(trap) + int'(pipe_stall);
    end
    check("mask_bits", 32'(seen), 32'd0);
    irq_timer = 1'b0;

    // mret
    mret_valid = 1'b1;
    mepc       = 32'h1236;
    tick();
    mret_valid = 1'b0;
    check("mret_pulse", 32'(mret_pulse), 32'd1);
    check("mret_rv", 32'(redirect_valid), 32'd1);
    check("mret_rpc", redirect_pc, 32'h1234);
    check("mret_stall", 32'(pipe_stall), 32'd1);
    tick();
    check("mret_done", 32'(pipe_stall), 32'd0);
    check("mret_once", 32'(mret_pulse), 32'd0);

    // exception beats mret
    exc_valid  = 1'b1;
    exc_cause  = 4'd5;
    exc_value  = 32'h55;
    exc_pc     = 32'h300;
    mret_valid = 1'b1;
    tick();
    exc_valid  = 1'b0;
    mret_valid = 1'b0;
    check("excmret_trap", 32'(trap), 32'd1);
    check("excmret_cause", 32'(trap_cause), 32'd5);
    check("excmret_nomret", 32'(mret_pulse), 32'd0);
    finish_ack("excmret", 32'h404, 32'h404);

    // ack timeout
    exc_valid = 1'b1;
    exc_cause = 4'd1;
    exc_value = 32'h0;
    exc_pc    = 32'h500;
    tick();
    exc_valid = 1'b0;
    check("to_trap", 32'(trap), 32'd1);
    seen = 0;
    for (int k = 1; k < 16; k++) begin
      tick();
      seen += int'(redirect_valid) + int'(seq_fault);
    end
    check("to_early", 32'(seen), 32'd0);
    tick();
    check("to_rv", 32'(redirect_valid), 32'd1);
    check("to_fault", 32'(seq_fault), 32'd1);
    check("to_rpc", redirect_pc, 32'd0);
    tick();
    exc_valid = 1'b1;
    exc_cause = 4'd4;
    exc_pc    = 32'h700;
    tick();
    exc_valid = 1'b0;
    finish_ack("post_to", 32'h800, 32'h800);
    check("fault_sticky", 32'(seq_fault), 32'd1);

    // reset during WAIT_ACK
    exc_valid = 1'b1;
    exc_cause = 4'd6;
    exc_value = 32'h66;
    exc_pc    = 32'h600;
    tick();
    exc_valid = 1'b0;
    tick();
    check("mid_stall", 32'(pipe_stall), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("ar_trap", 32'(trap), 32'd0);
    check("ar_stall", 32'(pipe_stall), 32'd0);
    check("ar_fault", 32'(seq_fault), 32'd0);
    check("ar_cause", 32'(trap_cause), 32'd0);
    check("ar_pc", trap_pc, 32'd0);
    check("ar_val", trap_value, 32'd0);
    check("ar_rpc", redirect_pc, 32'd0);
    check("ar_rv", 32'(redirect_valid), 32'd0);
    tick();
    rst_n = 1'b1;
    seen  = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen += int'(trap) + int'(redirect_valid) + int'(pipe_stall);
    end
    check("ar_quiet", 32'(seen), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
